// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer capture path.
package fb_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
  localparam int FB_ADDR_W = 17;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE
  } cap_state_t;

endpackage

// File: rtl/fb_capture_ctrl_if.sv
// Frame-buffer write port: the capture controller drives, the buffer receives.
interface fb_capture_ctrl_if
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/fb_addr_gen.sv
// Row/column/line-base counters; address is line_base + col, so no multiplier.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              pix_inc,
  input  logic              line_inc,
  output logic [ADDR_W-1:0] addr,
  output logic              col_full,
  output logic              col_last,
  output logic              last_row
);
  localparam int COL_W = $clog2(WIDTH + 1);
  localparam int ROW_W = $clog2(HEIGHT + 1);

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] line_base;

  // line advance takes priority over a same-cycle pixel: the pixel was
  // already written at the old column, so the column simply restarts
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col       <= '0;
      row       <= '0;
      line_base <= '0;
    end else if (line_inc) begin
      col       <= '0;
      row       <= row + 1'b1;
      line_base <= line_base + ADDR_W'(WIDTH);
    end else if (pix_inc) begin
      col <= col + 1'b1;
    end
  end

  assign addr     = line_base + ADDR_W'(col);
  assign col_full = (col == COL_W'(WIDTH));
  assign col_last = (col == COL_W'(WIDTH - 1));
  assign last_row = (row == ROW_W'(HEIGHT - 1));

endmodule

// File: rtl/fb_capture_ctrl.sv
// Write-side sequencer: camera pixel stream -> frame-buffer write strobes.
//
// state   | meaning
// IDLE    | not capturing, waiting for arm
// ARMED   | waiting for frame_start
// CAPTURE | writing pixels of the current frame
module fb_capture_ctrl
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              continuous,
  input  logic              clr_err,
  input  logic              frame_start,
  input  logic              line_end,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  fb_capture_ctrl_if.master wr,
  output logic              busy,
  output logic              frame_done,
  output logic              err_short_frame,
  output logic              err_long_line,
  output logic              err_short_line
);
  cap_state_t        state_q, state_d;
  logic              clear, pix_inc, line_inc;
  logic              wr_fire, done_d;
  logic              ev_short_frame, ev_long_line, ev_short_line;
  logic [ADDR_W-1:0] addr;
  logic              col_full, col_last, last_row;

  fb_addr_gen #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .pix_inc (pix_inc),
    .line_inc(line_inc),
    .addr    (addr),
    .col_full(col_full),
    .col_last(col_last),
    .last_row(last_row)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state, counter controls and error events
  always_comb begin
    state_d        = state_q;
    clear          = 1'b0;
    pix_inc        = 1'b0;
    line_inc       = 1'b0;
    wr_fire        = 1'b0;
    done_d         = 1'b0;
    ev_short_frame = 1'b0;
    ev_long_line   = 1'b0;
    ev_short_line  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) state_d = ARMED;
      end
      ARMED: begin
        if (frame_start) begin
          state_d = CAPTURE;
          clear   = 1'b1;
        end
      end
      CAPTURE: begin
        if (frame_start) begin
          // restart wins over any pixel or line_end in the same cycle
          ev_short_frame = 1'b1;
          clear          = 1'b1;
        end else begin
          if (pix_valid) begin
            if (!col_full) begin
              wr_fire = 1'b1;
              pix_inc = 1'b1;
            end else begin
              ev_long_line = 1'b1;
            end
          end
          if (line_end) begin
            // a pixel arriving with line_end counts towards the line length
            ev_short_line = !col_full && !(wr_fire && col_last);
            line_inc      = 1'b1;
            if (last_row) begin
              done_d  = 1'b1;
              state_d = continuous ? ARMED : IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // registered write port and frame-done pulse; address/data hold between writes
  always_ff @(posedge clk) begin
    if (rst) begin
      wr.wr_en   <= 1'b0;
      wr.wr_addr <= '0;
      wr.wr_data <= '0;
      frame_done <= 1'b0;
    end else begin
      wr.wr_en   <= wr_fire;
      frame_done <= done_d;
      if (wr_fire) begin
        wr.wr_addr <= addr;
        wr.wr_data <= pix_data;
      end
    end
  end

  // sticky error flags; a new event beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      err_short_frame <= 1'b0;
      err_long_line   <= 1'b0;
      err_short_line  <= 1'b0;
    end else begin
      err_short_frame <= (err_short_frame & ~clr_err) | ev_short_frame;
      err_long_line   <= (err_long_line   & ~clr_err) | ev_long_line;
      err_short_line  <= (err_short_line  & ~clr_err) | ev_short_line;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_fb_capture_ctrl.sv
// Bench: a full-size controller and an 8x4 controller share one stimulus
// stream; both are compared every cycle against a frame-level model.
module tb_fb_capture_ctrl;
  import fb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0, continuous = 1'b0, clr_err = 1'b0;
  logic       frame_start = 1'b0, line_end = 1'b0, pix_valid = 1'b0;
  logic [7:0] pix_data = 8'd0;

  logic busy_b, done_b, esf_b, ell_b, esl_b;
  logic busy_s, done_s, esf_s, ell_s, esl_s;

  fb_capture_ctrl_if #(.ADDR_W(17)) wr_b ();
  fb_capture_ctrl_if #(.ADDR_W(5))  wr_s ();

  always #5 clk = ~clk;

  fb_capture_ctrl #(.WIDTH(320), .HEIGHT(240), .ADDR_W(17)) dut_big (
    .clk(clk), .rst(rst), .arm(arm), .continuous(continuous), .clr_err(clr_err),
    .frame_start(frame_start), .line_end(line_end), .pix_valid(pix_valid),
    .pix_data(pix_data), .wr(wr_b.master), .busy(busy_b), .frame_done(done_b),
    .err_short_frame(esf_b), .err_long_line(ell_b), .err_short_line(esl_b)
  );

  fb_capture_ctrl #(.WIDTH(8), .HEIGHT(4), .ADDR_W(5)) dut_small (
    .clk(clk), .rst(rst), .arm(arm), .continuous(continuous), .clr_err(clr_err),
    .frame_start(frame_start), .line_end(line_end), .pix_valid(pix_valid),
    .pix_data(pix_data), .wr(wr_s.master), .busy(busy_s), .frame_done(done_s),
    .err_short_frame(esf_s), .err_long_line(ell_s), .err_short_line(esl_s)
  );

  int checks = 0;
  int errors = 0;

  // frame-level reference model, index 0 = full size, 1 = 8x4
  int mw[2];
  int mh[2];
  bit m_arm[2], m_cap[2];
  int m_row[2], m_col[2];
  bit m_esf[2], m_ell[2], m_esl[2];
  bit x_we[2], x_done[2];
  int x_addr[2], x_data[2];
  int m_done_cnt[2];

  int nwr_b = 0, ndone_b = 0, ndone_s = 0;
  int last_addr_b = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
      if (errors >= 50) begin
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  endtask

  task automatic model_step(input int d);
    bit sf, ll, sl;
    sf = 0; ll = 0; sl = 0;
    x_we[d] = 0; x_done[d] = 0;
    if (rst) begin
      m_arm[d] = 0; m_cap[d] = 0; m_row[d] = 0; m_col[d] = 0;
      m_esf[d] = 0; m_ell[d] = 0; m_esl[d] = 0;
      x_addr[d] = 0; x_data[d] = 0;
      return;
    end
    if (m_cap[d]) begin
      if (frame_start) begin
        sf = 1; m_row[d] = 0; m_col[d] = 0;
      end else begin
        if (pix_valid) begin
          if (m_col[d] < mw[d]) begin
            x_we[d] = 1;
            x_addr[d] = m_row[d] * mw[d] + m_col[d];
            x_data[d] = int'(pix_data);
            m_col[d]++;
          end else ll = 1;
        end
        if (line_end) begin
          if (m_col[d] < mw[d]) sl = 1;
          m_col[d] = 0;
          m_row[d]++;
          if (m_row[d] == mh[d]) begin
            x_done[d] = 1;
            m_done_cnt[d]++;
            m_cap[d] = 0;
            m_arm[d] = continuous;
          end
        end
      end
    end else if (m_arm[d]) begin
      if (frame_start) begin
        m_arm[d] = 0; m_cap[d] = 1; m_row[d] = 0; m_col[d] = 0;
      end
    end else if (arm) begin
      m_arm[d] = 1;
    end
    m_esf[d] = (m_esf[d] && !clr_err) || sf;
    m_ell[d] = (m_ell[d] && !clr_err) || ll;
    m_esl[d] = (m_esl[d] && !clr_err) || sl;
  endtask

  function automatic logic [31:0] pack(input logic we, input logic dn, input logic bz,
                                       input logic e0, input logic e1, input logic e2,
                                       input logic [7:0] dat, input logic [16:0] adr);
    return {1'b0, we, dn, bz, e0, e1, e2, dat, adr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);
    chk("outs_big",
        pack(wr_b.wr_en, done_b, busy_b, esf_b, ell_b, esl_b, wr_b.wr_data, wr_b.wr_addr),
        pack(x_we[0], x_done[0], m_arm[0] || m_cap[0], m_esf[0], m_ell[0], m_esl[0],
             8'(x_data[0]), 17'(x_addr[0])));
    chk("outs_small",
        pack(wr_s.wr_en, done_s, busy_s, esf_s, ell_s, esl_s, wr_s.wr_data, {12'd0, wr_s.wr_addr}),
        pack(x_we[1], x_done[1], m_arm[1] || m_cap[1], m_esf[1], m_ell[1], m_esl[1],
             8'(x_data[1]), 17'(x_addr[1])));
    if (wr_b.wr_en) begin
      nwr_b++;
      last_addr_b = int'(wr_b.wr_addr);
    end
    if (done_b) ndone_b++;
    if (done_s) ndone_s++;
  endtask

  task automatic pix(input bit le);
    pix_valid = 1'b1;
    pix_data  = 8'($urandom);
    line_end  = le;
    tick();
    pix_valid = 1'b0;
    line_end  = 1'b0;
  endtask

  // npix pixels; the line_end rides on the last pixel or follows it
  task automatic send_line(input int npix, input bit coincident);
    for (int i = 0; i < npix; i++) pix(coincident && (i == npix - 1));
    if (!coincident) begin
      line_end = 1'b1;
      tick();
      line_end = 1'b0;
    end
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    mw[0] = 320; mh[0] = 240;
    mw[1] = 8;   mh[1] = 4;
    m_done_cnt[0] = 0; m_done_cnt[1] = 0;

    // reset
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy_b), 32'd0);
    chk("rst_wr_en", 32'(wr_b.wr_en), 32'd0);
    chk("rst_errs", 32'({esf_b, ell_b, esl_b}), 32'd0);

    // arm, then short line on row 0, long line on row 5
    continuous = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("busy_rise", 32'(busy_b), 32'd1);
    tick();
    pulse_fs();
    send_line(300, 0);
    chk("short_line_flag", 32'(esl_b), 32'd1);
    pix(0);
    chk("row1_first_addr", 32'(wr_b.wr_addr), 32'd320);
    send_line(319, 1);
    for (int r = 2; r < 5; r++) send_line(320, 1);
    send_line(322, 0);
    chk("long_line_flag", 32'(ell_b), 32'd1);
    pix(0);
    chk("row6_first_addr", 32'(wr_b.wr_addr), 32'd1920);
    send_line(319, 1);

    // restart mid-frame with a coincident pixel (dropped)
    for (int i = 0; i < 50; i++) pix(0);
    pix_valid = 1'b1;
    frame_start = 1'b1;
    tick();
    pix_valid = 1'b0;
    frame_start = 1'b0;
    chk("restart_drop", 32'(wr_b.wr_en), 32'd0);
    chk("short_frame_flag", 32'(esf_b), 32'd1);
    pix(0);
    chk("restart_addr", 32'(wr_b.wr_addr), 32'd0);

    // clear coincident with a short-line event: that flag survives
    clr_err = 1'b1;
    line_end = 1'b1;
    tick();
    clr_err = 1'b0;
    line_end = 1'b0;
    chk("clr_with_event", 32'({esf_b, ell_b, esl_b}), 32'b001);

    // restart again, then a full frame in continuous mode
    continuous = 1'b1;
    pulse_fs();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    nwr_b = 0;
    ndone_b = 0;
    for (int r = 0; r < 240; r++) begin
      send_line(320, 1);
      if (r == 238) chk("no_early_done", 32'(ndone_b), 32'd0);
    end
    chk("done_with_write", 32'({done_b, wr_b.wr_en}), 32'b11);
    chk("frame_writes", 32'(nwr_b), 32'd76800);
    chk("frame_done_count", 32'(ndone_b), 32'd1);
    chk("last_addr", 32'(last_addr_b), 32'd76799);
    chk("errs_clean_frame", 32'({esf_b, ell_b, esl_b}), 32'd0);
    tick();
    chk("armed_busy", 32'(busy_b), 32'd1);

    // next frame accepted without arm, then reset mid-frame
    pulse_fs();
    pix(0);
    chk("rearm_wr_en", 32'(wr_b.wr_en), 32'd1);
    chk("rearm_addr", 32'(wr_b.wr_addr), 32'd0);
    send_line(319, 1);
    send_line(320, 1);
    for (int i = 0; i < 20; i++) pix(0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", 32'(busy_b), 32'd0);
    chk("rst_mid_outs", 32'({wr_b.wr_en, done_b, wr_b.wr_data, wr_b.wr_addr}), 32'd0);
    nwr_b = 0;
    pulse_fs();
    for (int i = 0; i < 30; i++) pix(0);
    chk("no_arm_writes", 32'(nwr_b), 32'd0);

    // randomized traffic, mainly exercising the 8x4 instance
    for (int i = 0; i < 2000; i++) begin
      rst         = ($urandom_range(0, 999) == 0);
      arm         = ($urandom_range(0, 15) == 0);
      continuous  = 1'($urandom_range(0, 1));
      clr_err     = ($urandom_range(0, 39) == 0);
      frame_start = ($urandom_range(0, 149) == 0);
      line_end    = ($urandom_range(0, 8) == 0);
      pix_valid   = ($urandom_range(0, 3) != 0);
      pix_data    = 8'($urandom);
      tick();
    end
    rst = 1'b0; arm = 1'b0; clr_err = 1'b0;
    frame_start = 1'b0; line_end = 1'b0; pix_valid = 1'b0;
    repeat (3) tick();
    chk("small_done_count", 32'(ndone_s), 32'(m_done_cnt[1]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
